// File: rtl/jk_ms_reg.sv
// ---------------------------------------------------------------------------
// jk_ms_reg : multi-bit master-slave register bank with JK semantics
//
// The master register (qm) computes the next state every enabled edge using
// one of four modes; the slave register (qs) copies the master on every
// non-reset edge, so qs is qm delayed by exactly one clock.
//
// Parameters
//   WIDTH      bit width of master and slave registers (>= 2)
//   MAX_COUNT  terminal value for the count modes (1 .. 2**WIDTH-1)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears qm, qs, wrap)
//   en       master update enable
//   mode     00 per-bit JK, 01 count-up, 10 count-down, 11 shift-left
//   j, k     per-bit J/K inputs (mode 00 only)
//   ser_in   serial input shifted into bit 0 (mode 11 only)
//   qm       master register
//   qs       slave register
//   wrap     registered one-cycle pulse, high while qm shows a wrapped value
//   ser_out  qs[WIDTH-1]
// ---------------------------------------------------------------------------
module jk_ms_reg #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] qm,
    output logic [WIDTH-1:0] qs,
    output logic             wrap,
    output logic             ser_out
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] qm_q;
    logic [WIDTH-1:0] qm_d;
    logic [WIDTH-1:0] qs_q;
    logic             wrap_q;
    logic             wrap_d;

    // Per-bit JK next value, evaluated independently for every bit.
    logic [WIDTH-1:0] jk_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_jk
            always_comb begin
                unique case ({j[gi], k[gi]})
                    2'b00:   jk_next[gi] = qm_q[gi];
                    2'b01:   jk_next[gi] = 1'b0;
                    2'b10:   jk_next[gi] = 1'b1;
                    default: jk_next[gi] = ~qm_q[gi];
                endcase
            end
        end
    endgenerate

    always_comb begin
        qm_d   = qm_q;
        wrap_d = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_JK: begin
                    qm_d = jk_next;
                end
                MODE_UP: begin
                    // >= rather than == so an out-of-range value left by
                    // JK mode also wraps back to 0.
                    if (qm_q >= MAX_VAL) begin
                        qm_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        qm_d = qm_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if ((qm_q == '0) || (qm_q > MAX_VAL)) begin
                        qm_d   = MAX_VAL;
                        wrap_d = 1'b1;
                    end else begin
                        qm_d = qm_q - ONE;
                    end
                end
                MODE_SHIFT: begin
                    qm_d = {qm_q[WIDTH-2:0], ser_in};
                end
                default: begin
                    qm_d = qm_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qm_q   <= '0;
            qs_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            qm_q   <= qm_d;
            qs_q   <= qm_q;   // slave follows master regardless of en
            wrap_q <= wrap_d;
        end
    end

    assign qm      = qm_q;
    assign qs      = qs_q;
    assign wrap    = wrap_q;
    assign ser_out = qs_q[WIDTH-1];

endmodule

// File: tb/tb_jk_ms_reg.sv
// ---------------------------------------------------------------------------
// tb_jk_ms_reg : directed self-checking bench for jk_ms_reg
// (WIDTH=4, MAX_COUNT=9). One line is printed per checked transaction.
// ---------------------------------------------------------------------------
module tb_jk_ms_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       ser_in;
    logic [3:0] qm;
    logic [3:0] qs;
    logic       wrap;
    logic       ser_out;

    int err_cnt   = 0;
    int check_cnt = 0;

    jk_ms_reg #(
        .WIDTH     (4),
        .MAX_COUNT (9)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .ser_in  (ser_in),
        .qm      (qm),
        .qs      (qs),
        .wrap    (wrap),
        .ser_out (ser_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state after an edge, one line per transaction.
    task automatic chk_state(input string tag, input logic [3:0] eqm, input logic [3:0] eqs,
                             input logic ewrap);
        $display("%-12s qm=%b qs=%b wrap=%b ser_out=%b", tag, qm, qs, wrap, ser_out);
        chk({tag, ".qm"},   32'(qm),   32'(eqm));
        chk({tag, ".qs"},   32'(qs),   32'(eqs));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
    endtask

    int up_seq  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int sh_bits [4]  = '{1, 0, 1, 1};
    int sh_seq  [4]  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

    initial begin
        int prev;
        rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; ser_in = 1'b0;

        // ---- reset and JK basics ----
        tick();
        tick();
        chk_state("reset", 4'h0, 4'h0, 1'b0);
        chk("reset.ser_out", 32'(ser_out), 32'd0);

        rst = 1'b0; en = 1'b1; mode = 2'b00; j = 4'b1010; k = 4'b0101;
        tick();
        chk_state("jk_set", 4'b1010, 4'b0000, 1'b0);
        j = 4'b1111; k = 4'b1111;
        tick();
        chk_state("jk_toggle", 4'b0101, 4'b1010, 1'b0);
        j = 4'b0000; k = 4'b0000;
        tick();
        chk_state("jk_hold", 4'b0101, 4'b0101, 1'b0);

        // ---- count-up with wrap; j/k driven to show they are ignored ----
        rst = 1'b1;
        tick();
        chk_state("rst_up", 4'h0, 4'h0, 1'b0);
        rst = 1'b0; mode = 2'b01; j = 4'hF; k = 4'hF;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_state($sformatf("up%0d", i), 4'(up_seq[i]), 4'(prev), 1'(up_wrap[i]));
            prev = up_seq[i];
        end

        // ---- count-down from an out-of-range JK-loaded value ----
        mode = 2'b00; j = 4'b1100; k = 4'b0011;
        tick();
        chk_state("ld_C", 4'hC, 4'h2, 1'b0);
        mode = 2'b10; j = 4'h0; k = 4'h0;
        tick();
        chk_state("dn_oor", 4'h9, 4'hC, 1'b1);
        tick();
        chk_state("dn_8", 4'h8, 4'h9, 1'b0);
        tick();
        chk_state("dn_7", 4'h7, 4'h8, 1'b0);
        mode = 2'b00; j = 4'h0; k = 4'hF;
        tick();
        chk_state("ld_0", 4'h0, 4'h7, 1'b0);
        mode = 2'b10;
        tick();
        chk_state("dn_zero", 4'h9, 4'h0, 1'b1);

        // ---- enable hold and slave catch-up ----
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_state("up_to5", 4'h5, 4'h4, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("hold%0d", i), 4'h5, 4'h5, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_state("resume6", 4'h6, 4'h5, 1'b0);

        // ---- shift-left ----
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 2'b11;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            ser_in = 1'(sh_bits[i]);
            tick();
            chk_state($sformatf("sh%0d", i), 4'(sh_seq[i]), 4'(prev), 1'b0);
            prev = sh_seq[i];
        end
        chk("sh3.ser_out", 32'(ser_out), 32'd0);
        ser_in = 1'b0;
        tick();
        chk_state("sh_out", 4'b0110, 4'b1011, 1'b0);
        chk("sh_out.ser_out", 32'(ser_out), 32'd1);

        // ---- reset mid-count ----
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk_state("up_to7", 4'h7, 4'h6, 1'b0);
        rst = 1'b1;
        tick();
        chk_state("mid_rst", 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        tick();
        chk_state("after_rst", 4'h1, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
